// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions, receiver FSM encoding.
// Shared by uart_rx_mmio and the transmit-side block that will reuse this register map.
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVR   = 2;
   localparam int ST_FERR  = 3;
   localparam int ST_PERR  = 4;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } rx_state_e;

   // Divisors below DIV_MIN would leave no room for a mid-bit sample.
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; the head entry is presented combinationally.
// A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output logic          drop_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok, push_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign drop_o  = push_i & ~push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchroniser, oversampling framer, receive FIFO, registers.
// Optional even-parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 12_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        wren,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        irq
);

   localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE);
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

   rx_state_e     state_q, state_d;
   logic          rx_m_q, rx_s_q;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   divreg_q, divreg_d;
   logic          par_bad_q, par_bad_d;
   logic          ferr_q, ferr_d, ovr_q, ovr_d, perr_q, perr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          push, ferr_set, perr_set, tick;
   logic          rd_acc, wr_acc, pop;
   logic [7:0]    head;
   logic          full, empty, drop;
   logic [CW-1:0] count;
   logic [7:0]    count8;
   logic          unused_ok;

   assign tick   = (cnt_q == '0);
   assign rd_acc = sel & ~wren;
   assign wr_acc = sel & wren;
   assign pop    = rd_acc & (addr == REG_DATA);
   assign count8 = 8'(count);

   // Framer: counters reload to div_q-1 so each bit spans exactly div_q clocks.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      div_d     = div_q;
      par_bad_d = par_bad_q;
      push      = 1'b0;
      ferr_set  = 1'b0;
      perr_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d   = S_START;
               div_d     = divreg_q;
               cnt_d     = divreg_q >> 1;
               par_bad_d = 1'b0;
            end
         end
         S_START: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else if (!rx_s_q) begin
               state_d = S_DATA;
               cnt_d   = div_q - 16'd1;
               bit_d   = 3'd0;
            end else state_d = S_IDLE;
         end
         S_DATA: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else begin
               shreg_d = {rx_s_q, shreg_q[7:1]};
               cnt_d   = div_q - 16'd1;
               bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_q == 3'd7) state_d = S_PARITY;
`else
               if (bit_q == 3'd7) state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else begin
               par_bad_d = ^{shreg_q, rx_s_q};
               perr_set  = par_bad_d;
               cnt_d     = div_q - 16'd1;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else if (rx_s_q) begin
               push    = ~par_bad_q;
               state_d = S_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_d  = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata_d  = '0;
      divreg_d = divreg_q;
      if (rd_acc) begin
         case (addr)
            REG_DATA:   rdata_d = empty ? 32'd0 : {23'd0, 1'b1, head};
            REG_STATUS: rdata_d = {16'd0, count8, 3'd0, perr_q, ferr_q, ovr_q, full, empty};
            REG_DIV:    rdata_d = {16'd0, divreg_q};
            default:    rdata_d = '0;
         endcase
      end
      if (wr_acc && addr == REG_DIV) divreg_d = clamp_div(wdata[15:0]);
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_comb begin
      ferr_d = (ferr_q & ~(wr_acc && addr == REG_STATUS && wdata[ST_FERR])) | ferr_set;
      ovr_d  = (ovr_q  & ~(wr_acc && addr == REG_STATUS && wdata[ST_OVR]))  | drop;
`ifdef UART_RX_PARITY_EN
      perr_d = (perr_q & ~(wr_acc && addr == REG_STATUS && wdata[ST_PERR])) | perr_set;
`else
      perr_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         div_q     <= DIV_RESET;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         div_q     <= div_d;
         par_bad_q <= par_bad_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m_q   <= 1'b1;
         rx_s_q   <= 1'b1;
         divreg_q <= DIV_RESET;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         perr_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rx_m_q   <= rx;
         rx_s_q   <= rx_m_q;
         divreg_q <= divreg_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         perr_q   <= perr_d;
         rdata_q  <= rdata_d;
      end
   end

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .din_i   (shreg_q),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count),
      .drop_o  (drop)
   );

   assign rdata     = rdata_q;
   assign irq       = ~empty | ferr_q | ovr_q | perr_q;
   assign unused_ok = ^{wdata[31:16], wdata[4], perr_set};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio: register reads queue expected values, a monitor compares rdata.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_mmio;

   localparam int BIT_CLK = 16;

   logic        clk = 1'b0;
   logic        rst, sel, wren, rx, irq;
   logic [1:0]  addr;
   logic [31:0] wdata, rdata;
   logic        rd_seen = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   string       nm_q[$];

   uart_rx_mmio dut (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel),
      .wren  (wren),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .rx    (rx),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_seen <= sel & ~wren;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: rdata is valid the cycle after a read strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_seen) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got 0x%08h want no read", rdata);
            end else check(nm_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
   end

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
      @(negedge clk);
      sel = 1'b1; wren = 1'b0; addr = a;
      exp_q.push_back(exp);
      nm_q.push_back(nm);
      @(negedge clk);
      sel = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; wren = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wren = 1'b0;
   endtask

   task automatic bitw();
      repeat (BIT_CLK) @(negedge clk);
   endtask

   // Frame with optional low stop bit; the caller releases the line after a low stop.
   task automatic send_byte(input logic [7:0] b, input bit stop_hi, input bit par_flip);
      rx = 1'b0; bitw();
      for (int i = 0; i < 8; i++) begin
         rx = b[i]; bitw();
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip; bitw();
`endif
      rx = stop_hi;
      if (stop_hi) begin
         bitw(); bitw(); bitw();
      end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; wren = 1'b0; addr = 2'd0; wdata = '0; rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("reset_irq", {31'd0, irq}, 32'd0);
      rd(2'd1, 32'h0000_0001, "reset_status");
      rd(2'd2, 32'd1250, "reset_div");
      rd(2'd3, 32'h0000_0000, "reserved_read");
      rd(2'd0, 32'h0000_0000, "empty_data");
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0000_0001, "status_after_ignored_writes");
      wr(2'd2, 32'd1);
      rd(2'd2, 32'd2, "div_clamp");
      wr(2'd2, 32'd16);
      rd(2'd2, 32'd16, "div_16");

      send_byte(8'hA5, 1'b1, 1'b0);
      rd(2'd1, 32'h0000_0100, "status_one_byte");
      check("irq_one_byte", {31'd0, irq}, 32'd1);
      rd(2'd0, 32'h0000_01A5, "data_a5");
      rd(2'd1, 32'h0000_0001, "status_after_pop");
      check("irq_after_pop", {31'd0, irq}, 32'd0);

      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      rd(2'd1, 32'h0000_0001, "status_glitch");

      send_byte(8'h3C, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      rd(2'd1, 32'h0000_0009, "status_ferr");
      check("irq_ferr", {31'd0, irq}, 32'd1);
      wr(2'd1, 32'h0000_0004);
      rd(2'd1, 32'h0000_0009, "ferr_kept_on_ovr_clear");
      wr(2'd1, 32'h0000_0008);
      rd(2'd1, 32'h0000_0001, "ferr_cleared");

      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0);
      rd(2'd1, 32'h0000_0806, "status_full_ovr");
      for (int i = 1; i <= 8; i++) rd(2'd0, 32'h0000_0100 | 32'(i), "data_order");
      rd(2'd0, 32'h0000_0000, "data_ninth");
      rd(2'd1, 32'h0000_0005, "status_ovr_empty");
      wr(2'd1, 32'h0000_0004);
      rd(2'd1, 32'h0000_0001, "ovr_cleared");
      check("irq_ovr_cleared", {31'd0, irq}, 32'd0);

`ifdef UART_RX_PARITY_EN
      send_byte(8'h03, 1'b1, 1'b1);
      rd(2'd1, 32'h0000_0011, "status_perr");
      wr(2'd1, 32'h0000_0010);
      rd(2'd1, 32'h0000_0001, "perr_cleared");
      send_byte(8'h03, 1'b1, 1'b0);
      rd(2'd0, 32'h0000_0103, "data_parity_ok");
`endif

      rx = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      rd(2'd1, 32'h0000_0001, "status_after_midframe_rst");
      rd(2'd2, 32'd1250, "div_after_rst");
      check("irq_after_rst", {31'd0, irq}, 32'd0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL pending_reads: got %0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
